// File: rtl/aram_arbiter.sv
// Four-way arbiter in front of the single-port ARAM: fixed priority dsp > smp > prs > ldr,
// with per-requester aging so a requester denied MAX_WAIT times in a row outranks the others.
module aram_arbiter #(
  parameter int AW       = 17,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          dsp_req,
  input  logic [AW-1:0] dsp_a,
  output logic          dsp_gnt,
  output logic          dsp_rvalid,
  input  logic          smp_req,
  input  logic          smp_we,
  input  logic [AW-1:0] smp_a,
  input  logic [7:0]    smp_din,
  output logic          smp_gnt,
  output logic          smp_rvalid,
  input  logic          prs_req,
  input  logic [AW-1:0] prs_a,
  output logic          prs_gnt,
  output logic          prs_rvalid,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_a,
  input  logic [7:0]    ldr_din,
  output logic          ldr_gnt,
  output logic [7:0]    rdata,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          busy
);

  // Handshake: a requester holds req/addr/we/din until it sees its gnt (registered, one cycle
  // wide, one cycle after the sampling edge); during that gnt cycle it either presents the next
  // request or drops req. Read data returns on rdata with the matching rvalid one cycle later.

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [7:0]    smp_wait, prs_wait, ldr_wait;
  logic          smp_urg, prs_urg, ldr_urg;
  logic [3:0]    win;        // one-hot {ldr, prs, smp, dsp}
  logic [AW-1:0] win_a;
  logic          win_rd, win_we;

  assign smp_urg = (smp_wait == MAX_W);
  assign prs_urg = (prs_wait == MAX_W);
  assign ldr_urg = (ldr_wait == MAX_W);

  // Urgent requesters first (dsp never ages), then the base order.
  always_comb begin
    win = 4'b0000;
    if (smp_req && smp_urg)      win = 4'b0010;
    else if (prs_req && prs_urg) win = 4'b0100;
    else if (ldr_req && ldr_urg) win = 4'b1000;
    else if (dsp_req)            win = 4'b0001;
    else if (smp_req)            win = 4'b0010;
    else if (prs_req)            win = 4'b0100;
    else if (ldr_req)            win = 4'b1000;
  end

  always_comb begin
    win_a = '0;
    if (win[0])      win_a = dsp_a;
    else if (win[1]) win_a = smp_a;
    else if (win[2]) win_a = prs_a;
    else if (win[3]) win_a = ldr_a;
  end

  assign win_rd = win[0] | win[2] | (win[1] & ~smp_we);
  assign win_we = win[3] | (win[1] & smp_we);

  function automatic logic [7:0] next_wait(input logic req, input logic won,
                                           input logic [7:0] cur);
    if (!req || won)    return 8'd0;
    else if (cur >= MAX_W) return MAX_W;
    else                return cur + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dsp_gnt    <= 1'b0;
      smp_gnt    <= 1'b0;
      prs_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      dsp_rvalid <= 1'b0;
      smp_rvalid <= 1'b0;
      prs_rvalid <= 1'b0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_din    <= 8'h00;
      smp_wait   <= 8'd0;
      prs_wait   <= 8'd0;
      ldr_wait   <= 8'd0;
    end else begin
      dsp_gnt <= win[0];
      smp_gnt <= win[1];
      prs_gnt <= win[2];
      ldr_gnt <= win[3];
      mem_rd  <= win_rd;
      mem_we  <= win_we;
      // Address and write data hold their last values while idle.
      if (|win)  mem_a   <= win_a;
      if (win_we) mem_din <= win[3] ? ldr_din : smp_din;
      // Only one grant per cycle, so mem_rd here belongs to whichever gnt is high.
      dsp_rvalid <= dsp_gnt;
      smp_rvalid <= smp_gnt & mem_rd;
      prs_rvalid <= prs_gnt;
      smp_wait <= next_wait(smp_req, win[1], smp_wait);
      prs_wait <= next_wait(prs_req, win[2], prs_wait);
      ldr_wait <= next_wait(ldr_req, win[3], ldr_wait);
    end
  end

  assign rdata = mem_dout;
  assign busy  = mem_rd | mem_we | dsp_rvalid | smp_rvalid | prs_rvalid;

endmodule

// File: doc/aram_arbiter.md
Name: aram_arbiter

Overview:
Shares the single-port 128 KiB ARAM between four requesters: DSP sample/BRR fetch, SMP bus, the SPC parser, and the host loader that streams the SPC file in.
- Every requester uses the same req/gnt/rvalid handshake.
- Fixed priority with per-requester aging, so no requester starves.
- Sits between the requesters and the ARAM block RAM, which has 1-cycle read latency.

Parameters:
AW, 17, ARAM address width (0x00000-0x0FFFF SMP space; 0x10000+ file header / DSP image).
MAX_WAIT, 8, consecutive denied cycles after which a requester becomes urgent (range 2..255).

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
dsp_req  in  1  DSP read request
dsp_a  in  AW  DSP address
dsp_gnt  out  1  DSP request accepted
dsp_rvalid  out  1  DSP read data valid on rdata
smp_req  in  1  SMP request
smp_we  in  1  SMP write (1) / read (0)
smp_a  in  AW  SMP address
smp_din  in  8  SMP write data
smp_gnt  out  1  SMP accepted
smp_rvalid  out  1  SMP read data valid
prs_req  in  1  parser read request
prs_a  in  AW  parser address
prs_gnt  out  1  parser accepted
prs_rvalid  out  1  parser read data valid
ldr_req  in  1  loader write request
ldr_a  in  AW  loader address
ldr_din  in  8  loader write data
ldr_gnt  out  1  loader accepted
rdata  out  8  read data, equal to mem_dout; meaningful only while some *_rvalid=1
mem_rd  out  1  ARAM read strobe
mem_we  out  1  ARAM write strobe
mem_a  out  AW  ARAM address
mem_din  out  8  ARAM write data
mem_dout  in  8  ARAM read data, valid the cycle after mem_rd
busy  out  1  an access is issued this cycle or a read is returning

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: all gnt, rvalid, mem_rd, mem_we and busy = 0; mem_a and mem_din = 0; wait counters = 0. Asserting resetn low mid-access drops any pending rvalid and never emits a late one.
- Request sampling:
  - At each clk edge the arbiter samples all *_req.
  - It picks at most one winner and registers gnt together with the memory command (mem_a, mem_din, mem_rd or mem_we).
  - Latency: request sampled at edge E; gnt and mem command high for exactly one cycle after E; for reads, the matching *_rvalid is high for exactly one cycle after E+1.
- Requester contract:
  - Hold req, address, we and din stable until gnt is seen.
  - During the gnt cycle, either present the next request (back-to-back, one access per cycle) or drop req.
  - The arbiter never double-grants one request.
- Request types: ldr is write-only (mem_we); dsp and prs are read-only (mem_rd). smp_we selects write or read; an SMP write produces no rvalid.
- Base priority: dsp > smp > prs > ldr.
- Aging:
  - smp, prs and ldr each have an 8-bit wait counter.
  - The counter increments each edge where req=1 and the requester is not granted; it saturates at MAX_WAIT.
  - It clears on grant or when req=0.
  - Counter == MAX_WAIT marks the requester urgent.
  - Urgent requesters beat every non-urgent requester, including dsp.
  - Among urgent requesters the base order applies.
  - dsp has no counter.
- Ordering: accesses complete in grant order. A write granted at cycle N is visible to any read granted at N+1 or later.
- Reads in flight: at most one at a time. Only the rvalid matching the previous cycle's read grant asserts.
- Idle: with no req, mem_rd = mem_we = 0, mem_a and mem_din hold their last values, and no gnt asserts.
- busy = mem_rd | mem_we | any rvalid.
- Address handling: addresses are forwarded unmodified; there is no wrap or range check.

Test Plan:
- Single parser read: prs_req with prs_a=0x10105, mem_dout at the read return = 0x3C -> prs_gnt 1 cycle after the sampling edge, mem_rd=1 with mem_a=0x10105 in the same cycle, then prs_rvalid=1 and rdata=0x3C one cycle later; no other gnt or rvalid.
- All four requesting from cycle 0, held until granted -> grant order dsp, smp, prs, ldr on consecutive cycles, each gnt exactly 1 cycle wide.
- Loader write then SMP read: ldr write 0x00200=0xA5, then smp read 0x00200 -> mem_we then mem_rd on adjacent cycles; smp_rvalid with rdata=0xA5.
- Starvation, MAX_WAIT=8: dsp_req held high continuously, ldr_req high from cycle 0 -> ldr_gnt on the 9th sampling edge; dsp is denied that cycle and regranted the next.
- Back-to-back SMP: smp reads at 0x0000, 0x0001, 0x0002 with req kept high -> three consecutive gnt/mem_rd cycles and three consecutive smp_rvalid pulses.
- Reset mid-read: resetn low the cycle after prs_gnt -> no prs_rvalid; all outputs 0 immediately; normal arbitration after resetn returns high.
